// File: rtl/nes_frame_capture.sv
// Assembles the NES core's visible pixel stream into ping-pong frame buffers and
// presents each complete frame to a reader through a registered read port.
module nes_frame_capture #(
    parameter int unsigned H_ACTIVE = 256,
    parameter int unsigned V_ACTIVE = 240,
    parameter int unsigned PIX_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [5:0]       color,
    input  logic [8:0]       cycle,
    input  logic [8:0]       scanline,
    input  logic             rd_en,
    input  logic [15:0]      rd_addr,
    output logic [PIX_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             frame_ready,
    input  logic             frame_ack,
    output logic [31:0]      frame_count,
    output logic             overrun,
    output logic             short_frame
);

    localparam int unsigned FRAME_PIX = H_ACTIVE * V_ACTIVE;
    localparam int unsigned MEM_DEPTH = 2 * FRAME_PIX;
    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned IDX_W     = 17;
    localparam int unsigned CNT_W     = 17;

    localparam logic [8:0]        H_LIM     = 9'(H_ACTIVE);
    localparam logic [8:0]        V_LIM     = 9'(V_ACTIVE);
    localparam logic [8:0]        H_LAST    = 9'(H_ACTIVE - 1);
    localparam logic [8:0]        V_LAST    = 9'(V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] FRAME_LIM = ADDR_W'(FRAME_PIX);
    localparam logic [IDX_W-1:0]  BUF1_BASE = IDX_W'(FRAME_PIX);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FRAME_PIX);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] pix_cnt, pix_cnt_nxt;
    logic             wr_sel, wr_sel_nxt;
    logic             ready_nxt;
    logic [31:0]      count_nxt;
    logic             overrun_nxt;
    logic             short_nxt;

    logic              visible_c;
    logic              origin_c;
    logic              last_c;
    logic              wr_en_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [IDX_W-1:0]  wr_idx_c;
    logic [IDX_W-1:0]  rd_idx_c;
    logic              rd_in_range_c;
    logic [PIX_W-1:0]  wr_data_c;

    logic [PIX_W-1:0] mem [MEM_DEPTH];

    // Pixel classification and buffer addressing; each buffer occupies half of mem.
    always_comb begin
        visible_c     = ce && (cycle < H_LIM) && (scanline < V_LIM);
        origin_c      = visible_c && (cycle == 9'd0) && (scanline == 9'd0);
        last_c        = visible_c && (cycle == H_LAST) && (scanline == V_LAST);
        wr_addr_c     = ADDR_W'(scanline) * ADDR_W'(H_ACTIVE) + ADDR_W'(cycle);
        wr_idx_c      = (wr_sel ? BUF1_BASE : '0) + IDX_W'(wr_addr_c);
        rd_idx_c      = (wr_sel ? '0 : BUF1_BASE) + IDX_W'(rd_addr);
        rd_in_range_c = rd_addr < FRAME_LIM;
        wr_data_c     = PIX_W'(color);
    end

    // Capture FSM: next state, pixel counter, swap and flag decisions.
    always_comb begin
        state_nxt   = state;
        pix_cnt_nxt = pix_cnt;
        wr_sel_nxt  = wr_sel;
        ready_nxt   = frame_ready & ~frame_ack;
        count_nxt   = frame_count;
        overrun_nxt = overrun;
        short_nxt   = short_frame;
        wr_en_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (origin_c) begin
                    wr_en_c     = 1'b1;
                    pix_cnt_nxt = CNT_W'(1);
                    state_nxt   = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (visible_c) begin
                    wr_en_c = 1'b1;
                    if (origin_c) begin
                        pix_cnt_nxt = CNT_W'(1);
                        if (pix_cnt != '0) short_nxt = 1'b1;
                    end else if (last_c) begin
                        pix_cnt_nxt = '0;
                        // Ack is folded into ready_nxt first, so a same-cycle ack frees the reader.
                        if (pix_cnt + CNT_W'(1) != CNT_FULL) begin
                            short_nxt = 1'b1;
                        end else if (!ready_nxt) begin
                            wr_sel_nxt = ~wr_sel;
                            ready_nxt  = 1'b1;
                            count_nxt  = frame_count + 32'd1;
                        end else begin
                            overrun_nxt = 1'b1;
                        end
                    end else begin
                        pix_cnt_nxt = pix_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            pix_cnt     <= '0;
            wr_sel      <= 1'b0;
            frame_ready <= 1'b0;
            frame_count <= '0;
            overrun     <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            state       <= state_nxt;
            pix_cnt     <= pix_cnt_nxt;
            wr_sel      <= wr_sel_nxt;
            frame_ready <= ready_nxt;
            frame_count <= count_nxt;
            overrun     <= overrun_nxt;
            short_frame <= short_nxt;
        end
    end

    // Frame buffer write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) mem[wr_idx_c] <= wr_data_c;
    end

    // Registered read port on the presented buffer; out-of-range addresses read as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_in_range_c ? mem[rd_idx_c] : '0;
        end
    end

endmodule

// File: tb/tb_nes_frame_capture.sv
// Directed bench for nes_frame_capture using a reduced 16x8 frame so each frame
// takes a few hundred cycles; expected pixels come from the (scanline^cycle)+k pattern.
module tb_nes_frame_capture;

    localparam int H  = 16;
    localparam int V  = 8;
    localparam int FP = H * V;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic [5:0]  color;
    logic [8:0]  cycle;
    logic [8:0]  scanline;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        frame_ready;
    logic        frame_ack;
    logic [31:0] frame_count;
    logic        overrun;
    logic        short_frame;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  exp;
    } rd_vec_t;

    rd_vec_t vec [7];

    always #5 clk = ~clk;

    nes_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .ce          (ce),
        .color       (color),
        .cycle       (cycle),
        .scanline    (scanline),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .frame_ready (frame_ready),
        .frame_ack   (frame_ack),
        .frame_count (frame_count),
        .overrun     (overrun),
        .short_frame (short_frame)
    );

    function automatic logic [7:0] exp_pix(input int k, input int s, input int c);
        logic [5:0] col;
        col = 6'((s ^ c) + k);
        return {2'b00, col};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pix(input int c, input int s, input int col, input bit ack, input int gap);
        @(negedge clk);
        ce        = 1'b1;
        cycle     = 9'(c);
        scanline  = 9'(s);
        color     = 6'(col);
        frame_ack = ack;
        repeat (gap) begin
            @(negedge clk);
            ce        = 1'b0;
            frame_ack = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ce        = 1'b0;
            frame_ack = 1'b0;
        end
    endtask

    // Streams scanlines s_start..s_end of pattern k; skip drops one scanline entirely.
    task automatic send_frame(input int k, input int skip, input int gap, input bit noise,
                              input bit ack_last, input int s_start, input int s_end);
        for (int s = s_start; s <= s_end; s++) begin
            if (s != skip) begin
                for (int c = 0; c < H; c++)
                    pix(c, s, int'(exp_pix(k, s, c)), ack_last && s == V-1 && c == H-1, gap);
            end
            if (noise)
                for (int c = H; c < H + 4; c++) pix(c, s, 63, 1'b0, gap);
        end
        if (noise)
            for (int s = V; s < V + 2; s++)
                for (int c = 0; c < 4; c++) pix(c, s, 63, 1'b0, gap);
    endtask

    task automatic read_check(input string name, input logic [15:0] addr, input logic [7:0] exp);
        @(negedge clk);
        rd_en   = 1'b1;
        rd_addr = addr;
        @(negedge clk);
        rd_en = 1'b0;
        check({name, "_valid"}, 32'(rd_valid), 32'd1);
        check({name, "_data"}, 32'(rd_data), 32'(exp));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        vec[0] = '{addr: 16'h0000, exp: 8'h00};
        vec[1] = '{addr: 16'h0015, exp: 8'h04};
        vec[2] = '{addr: 16'h007F, exp: 8'h08};
        vec[3] = '{addr: 16'h0035, exp: 8'h06};
        vec[4] = '{addr: 16'h0064, exp: 8'h02};
        vec[5] = '{addr: 16'h0080, exp: 8'h00};
        vec[6] = '{addr: 16'hFFFF, exp: 8'h00};

        reset = 1'b0; ce = 1'b0; color = '0; cycle = '0; scanline = '0;
        rd_en = 1'b0; rd_addr = '0; frame_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_ready", 32'(frame_ready), 32'd0);
        check("rst_count", frame_count, 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_short", 32'(short_frame), 32'd0);
        reset = 1'b1;
        idle(2);

        // Full frame presented, then table-driven reads of the presented buffer.
        send_frame(0, -1, 0, 1'b0, 1'b0, 0, V-1);
        idle(2);
        check("t2_ready", 32'(frame_ready), 32'd1);
        check("t2_count", frame_count, 32'd1);
        check("t2_overrun", 32'(overrun), 32'd0);
        check("t2_short", 32'(short_frame), 32'd0);
        for (int i = 0; i < 7; i++)
            read_check($sformatf("t2_rd%0d", i), vec[i].addr, vec[i].exp);

        // Asynchronous reset mid-frame, then the tail of that frame must be ignored.
        send_frame(0, -1, 0, 1'b0, 1'b0, 0, 3);
        @(negedge clk);
        ce = 1'b0; rd_en = 1'b1; rd_addr = 16'h0015;
        @(posedge clk);
        #2;
        check("t1_pre_valid", 32'(rd_valid), 32'd1);
        check("t1_pre_data", 32'(rd_data), 32'h04);
        reset = 1'b0;
        #1;
        check("t1_async_valid", 32'(rd_valid), 32'd0);
        check("t1_async_data", 32'(rd_data), 32'd0);
        check("t1_async_ready", 32'(frame_ready), 32'd0);
        check("t1_async_count", frame_count, 32'd0);
        @(negedge clk);
        reset = 1'b1; rd_en = 1'b0;
        send_frame(0, -1, 0, 1'b0, 1'b0, 4, V-1);
        idle(2);
        check("t1_tail_count", frame_count, 32'd0);
        check("t1_tail_ready", 32'(frame_ready), 32'd0);
        check("t1_tail_short", 32'(short_frame), 32'd0);

        // Second complete frame without ack is dropped.
        send_frame(1, -1, 0, 1'b0, 1'b0, 0, V-1);
        idle(2);
        check("t3_ready1", 32'(frame_ready), 32'd1);
        check("t3_count1", frame_count, 32'd1);
        send_frame(2, -1, 0, 1'b0, 1'b0, 0, V-1);
        idle(2);
        check("t3_overrun", 32'(overrun), 32'd1);
        check("t3_count2", frame_count, 32'd1);
        check("t3_ready2", 32'(frame_ready), 32'd1);
        read_check("t3_rd21", 16'd21, exp_pix(1, 1, 5));
        read_check("t3_rd127", 16'd127, exp_pix(1, 7, 15));

        // Ack coincident with the last pixel presents the new frame.
        do_reset();
        send_frame(3, -1, 0, 1'b0, 1'b0, 0, V-1);
        idle(2);
        send_frame(4, -1, 0, 1'b0, 1'b1, 0, V-1);
        idle(2);
        check("t4_overrun", 32'(overrun), 32'd0);
        check("t4_count", frame_count, 32'd2);
        check("t4_ready", 32'(frame_ready), 32'd1);
        read_check("t4_rd21", 16'd21, exp_pix(4, 1, 5));
        read_check("t4_rd0", 16'd0, exp_pix(4, 0, 0));
        @(negedge clk); frame_ack = 1'b1;
        @(negedge clk); frame_ack = 1'b0;
        check("t4_ack_clears", 32'(frame_ready), 32'd0);
        @(negedge clk); frame_ack = 1'b1;
        @(negedge clk); frame_ack = 1'b0;
        check("t4_ack_idle_ready", 32'(frame_ready), 32'd0);
        check("t4_ack_idle_count", frame_count, 32'd2);

        // Frame with a missing scanline is flagged and not presented.
        do_reset();
        send_frame(5, 3, 0, 1'b0, 1'b0, 0, V-1);
        idle(2);
        check("t5_short", 32'(short_frame), 32'd1);
        check("t5_ready", 32'(frame_ready), 32'd0);
        check("t5_count", frame_count, 32'd0);
        send_frame(6, -1, 0, 1'b0, 1'b0, 0, V-1);
        idle(2);
        check("t5_next_ready", 32'(frame_ready), 32'd1);
        check("t5_next_count", frame_count, 32'd1);
        check("t5_next_overrun", 32'(overrun), 32'd0);
        read_check("t5_rd21", 16'd21, exp_pix(6, 1, 5));

        // Gapped ce plus off-screen dots must give the same buffer as a clean frame.
        do_reset();
        send_frame(0, -1, 3, 1'b1, 1'b0, 0, V-1);
        idle(2);
        check("t6_ready", 32'(frame_ready), 32'd1);
        check("t6_count", frame_count, 32'd1);
        check("t6_short", 32'(short_frame), 32'd0);
        for (int a = 0; a < FP; a++)
            read_check($sformatf("t6_rd%0d", a), 16'(a), exp_pix(0, a / H, a % H));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
